fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the PC loaded on reset.
REQ-002 SHALL have parameter IMEM_BYTES, default 80, meaning the instruction memory size in bytes; a fetch is legal only while PC+4 <= IMEM_BYTES.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port Stall, input, 1, meaning hold PC and the IF/ID register.
REQ-006 SHALL have port Branch_Taken, input, 1, meaning redirect fetch and flush IF/ID.
REQ-007 SHALL have port Branch_Target, input, 64, meaning the redirect byte address.
REQ-008 SHALL have port Instruction, input, 32, the word returned combinationally by instruction memory for Inst_Address.
REQ-009 SHALL have port Inst_Address, output, 64, the current PC driven to instruction memory.
REQ-010 SHALL have port IFID_PC, output, 64, the registered PC of the fetched word.
REQ-011 SHALL have port IFID_Instruction, output, 32, the registered fetched word.
REQ-012 SHALL have port IFID_Valid, output, 1, set when IFID holds a real instruction.
REQ-013 SHALL have port Halted, output, 1, high while in state HALTED.
REQ-014 SHALL have port Fetch_Count, output, 32, the number of valid instructions delivered to IF/ID.

Function
REQ-015 SHALL implement two states: RUN and HALTED.
REQ-016 SHALL drive Inst_Address directly from the PC register, with zero combinational logic between them.
REQ-017 SHALL apply per-edge priority: reset > Branch_Taken > Stall > state action.
REQ-018 On Branch_Taken=1 in any state, SHALL perform all of the following, regardless of Stall:
- load PC <= {Branch_Target[63:2], 2'b00};
- load IFID_Valid <= 0 and IFID_Instruction <= 32'h00000013 (NOP);
- hold IFID_PC and Fetch_Count;
- go to state RUN.
REQ-019 On Stall=1 with Branch_Taken=0, SHALL hold PC, all IFID outputs, Fetch_Count and state.
REQ-020 In RUN with Stall=0 and Branch_Taken=0, while PC+4 <= IMEM_BYTES (compared at 65-bit width), SHALL perform all of the following:
- load IFID_PC <= PC, IFID_Instruction <= Instruction, IFID_Valid <= 1;
- load PC <= PC+4, modulo 2^64;
- increment Fetch_Count, wrapping 32'hFFFFFFFF -> 0.
REQ-021 In RUN with Stall=0 and Branch_Taken=0, while PC+4 > IMEM_BYTES, SHALL perform all of the following:
- hold PC;
- load IFID_Valid <= 0 and IFID_Instruction <= NOP;
- hold Fetch_Count;
- go to HALTED.
REQ-022 In HALTED with Stall=0 and Branch_Taken=0, SHALL hold PC and Fetch_Count and load a bubble (IFID_Valid <= 0, NOP) every edge.
REQ-023 SHALL never present Instruction to IF/ID with IFID_Valid=1 for an out-of-range PC.
REQ-024 SHALL give one-cycle fetch latency: the word at Inst_Address before edge N appears on IFID_* after edge N.
REQ-025 A branch to an out-of-range target SHALL enter RUN, then halt on the next non-stalled edge per REQ-021.

Reset
REQ-026 On reset=1 at a rising edge, SHALL perform all of the following, overriding all other inputs:
- set PC=RESET_PC;
- set IFID_PC=0, IFID_Instruction=32'h00000013, IFID_Valid=0;
- set Fetch_Count=0;
- enter state RUN, so Halted=0.
REQ-027 Reset asserted mid-operation, including in HALTED, during Stall, or with Branch_Taken, SHALL yield exactly the REQ-026 values after that edge.

Verification
REQ-028 Reset, then 3 edges with Stall=0 and Branch_Taken=0 -> Inst_Address goes 0,4,8,12; IFID_PC=8; IFID_Valid=1; Fetch_Count=3.
REQ-029 At PC=8, Stall=1 for 2 edges -> Inst_Address stays 8; IFID_PC, IFID_Instruction and Fetch_Count unchanged.
REQ-030 Branch_Taken=1 with Branch_Target=64'h2E and Stall=1 -> Inst_Address=64'h2C; IFID_Valid=0; IFID_Instruction=32'h00000013; Fetch_Count unchanged.
REQ-031 Free-run from 0 with IMEM_BYTES=80:
- Fetch_Count=20 and IFID_PC=76 after the PC=76 fetch;
- next edge gives Halted=1 and IFID_Valid=0, with Inst_Address held at 80;
- a later Branch_Taken to 0 gives Halted=0 and fetch resumes at 0.
REQ-032 reset=1 together with Branch_Taken=1 (target 64'h40) -> Inst_Address=RESET_PC; IFID_Valid=0; Fetch_Count=0; Halted=0.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage with an IF/ID pipeline register.
//
// The PC register drives instruction memory directly. The word that memory
// returns is captured into IF/ID on the next rising edge, together with the PC
// it came from. A taken branch redirects the PC and flushes IF/ID. A stall
// freezes the whole stage. Fetching past the end of instruction memory parks
// the unit in HALTED, and it stays there until a branch or a reset.
//
// Ports
//   clk              single clock; all state updates on the rising edge
//   reset            synchronous, active-high reset
//   Stall            hold PC, IF/ID, Fetch_Count and state
//   Branch_Taken     redirect fetch to Branch_Target and flush IF/ID
//   Branch_Target    redirect byte address (low two bits ignored)
//   Instruction      word returned combinationally for Inst_Address
//   Inst_Address     current PC, straight from the PC register
//   IFID_PC          PC of the word held in IF/ID
//   IFID_Instruction word held in IF/ID (NOP when invalid)
//   IFID_Valid       IF/ID holds a real instruction
//   Halted           unit is in state HALTED
//   Fetch_Count      number of valid instructions delivered to IF/ID
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int unsigned IMEM_BYTES = 80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch_Taken,
    input  logic [63:0] Branch_Target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic [63:0] IFID_PC,
    output logic [31:0] IFID_Instruction,
    output logic        IFID_Valid,
    output logic        Halted,
    output logic [31:0] Fetch_Count
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      r_state,       w_state_nxt;
    logic [63:0] r_pc,          w_pc_nxt;
    logic [63:0] r_ifid_pc,     w_ifid_pc_nxt;
    logic [31:0] r_ifid_instr,  w_ifid_instr_nxt;
    logic        r_ifid_valid,  w_ifid_valid_nxt;
    logic [31:0] r_fetch_count, w_fetch_count_nxt;

    logic        w_in_range;
    logic        w_unused_target_bits;

    // Compare at 65 bits so that a PC near 2^64 cannot wrap around and look
    // like a small, in-range address.
    assign w_in_range = ({1'b0, r_pc} + 65'd4) <= 65'(IMEM_BYTES);

    // Branch targets are word aligned; the low two bits are dropped.
    assign w_unused_target_bits = &Branch_Target[1:0];

    // Next-state and datapath. Priority: Branch_Taken > Stall > state action;
    // reset is applied on top of this in the register process.
    always_comb begin
        // NOTE: every output of this block gets a hold value first, so no path
        // through the if/else tree can leave one unassigned and infer a latch.
        w_state_nxt       = r_state;
        w_pc_nxt          = r_pc;
        w_ifid_pc_nxt     = r_ifid_pc;
        w_ifid_instr_nxt  = r_ifid_instr;
        w_ifid_valid_nxt  = r_ifid_valid;
        w_fetch_count_nxt = r_fetch_count;

        if (Branch_Taken) begin
            // Flush: IFID_PC and Fetch_Count keep their old values.
            w_pc_nxt         = {Branch_Target[63:2], 2'b00};
            w_ifid_instr_nxt = NOP;
            w_ifid_valid_nxt = 1'b0;
            w_state_nxt      = RUN;
        end else if (!Stall) begin
            if (r_state == RUN && w_in_range) begin
                w_ifid_pc_nxt     = r_pc;
                w_ifid_instr_nxt  = Instruction;
                w_ifid_valid_nxt  = 1'b1;
                w_pc_nxt          = r_pc + 64'd4;
                w_fetch_count_nxt = r_fetch_count + 32'd1;
            end else begin
                // Out of range in RUN, or already HALTED: the PC holds and a
                // bubble goes into IF/ID on every edge.
                w_ifid_instr_nxt = NOP;
                w_ifid_valid_nxt = 1'b0;
                w_state_nxt      = HALTED;
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples the values from before the edge, whatever order the
        // statements are written in.
        if (reset) begin
            r_state       <= RUN;
            r_pc          <= RESET_PC;
            r_ifid_pc     <= 64'd0;
            r_ifid_instr  <= NOP;
            r_ifid_valid  <= 1'b0;
            r_fetch_count <= 32'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pc          <= w_pc_nxt;
            r_ifid_pc     <= w_ifid_pc_nxt;
            r_ifid_instr  <= w_ifid_instr_nxt;
            r_ifid_valid  <= w_ifid_valid_nxt;
            r_fetch_count <= w_fetch_count_nxt;
        end
    end

    assign Inst_Address     = r_pc;
    assign IFID_PC          = r_ifid_pc;
    assign IFID_Instruction = r_ifid_instr;
    assign IFID_Valid       = r_ifid_valid;
    assign Halted           = (r_state == HALTED);
    assign Fetch_Count      = r_fetch_count;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Self-checking bench for fetch_unit with RESET_PC = 0 and IMEM_BYTES = 80.
// Instruction memory is a pure function of the address, so the expected
// IF/ID word can be derived from the expected IF/ID PC.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam int unsigned IMEM_BYTES = 80;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Stall = 1'b0;
    logic        Branch_Taken = 1'b0;
    logic [63:0] Branch_Target = 64'd0;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic [63:0] IFID_PC;
    logic [31:0] IFID_Instruction;
    logic        IFID_Valid;
    logic        Halted;
    logic [31:0] Fetch_Count;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(
        .RESET_PC   (64'h0),
        .IMEM_BYTES (IMEM_BYTES)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .Stall            (Stall),
        .Branch_Taken     (Branch_Taken),
        .Branch_Target    (Branch_Target),
        .Instruction      (Instruction),
        .Inst_Address     (Inst_Address),
        .IFID_PC          (IFID_PC),
        .IFID_Instruction (IFID_Instruction),
        .IFID_Valid       (IFID_Valid),
        .Halted           (Halted),
        .Fetch_Count      (Fetch_Count)
    );

    always #5 clk = ~clk;

    // Instruction memory contents: top byte A5 keeps every word distinct from NOP.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return {8'hA5, a[23:0]};
    endfunction

    assign Instruction = mem_word(Inst_Address);

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Architectural view: a PC, the IF/ID contents, a halted flag, a counter.
    logic [63:0] m_pc;
    logic [63:0] m_ifid_pc;
    logic [31:0] m_ifid_instr;
    logic        m_valid;
    logic        m_halted;
    logic [31:0] m_count;

    task automatic model_edge();
        logic [63:0] n_pc;
        logic [63:0] n_ifid_pc;
        logic [31:0] n_instr;
        logic        n_valid;
        logic        n_halted;
        logic [31:0] n_count;
        n_pc = m_pc; n_ifid_pc = m_ifid_pc; n_instr = m_ifid_instr;
        n_valid = m_valid; n_halted = m_halted; n_count = m_count;
        if (reset) begin
            n_pc = 64'd0; n_ifid_pc = 64'd0; n_instr = NOP;
            n_valid = 1'b0; n_halted = 1'b0; n_count = 32'd0;
        end else if (Branch_Taken) begin
            n_pc = Branch_Target & ~64'd3;
            n_instr = NOP; n_valid = 1'b0; n_halted = 1'b0;
        end else if (!Stall) begin
            // Legal fetch: the whole 4-byte word lies inside memory (no wrap).
            if (!m_halted && (m_pc <= 64'(IMEM_BYTES) - 64'd4)) begin
                n_ifid_pc = m_pc;
                n_instr   = mem_word(m_pc);
                n_valid   = 1'b1;
                n_pc      = m_pc + 64'd4;
                n_count   = m_count + 32'd1;
            end else begin
                n_instr = NOP; n_valid = 1'b0; n_halted = 1'b1;
            end
        end
        m_pc = n_pc; m_ifid_pc = n_ifid_pc; m_ifid_instr = n_instr;
        m_valid = n_valid; m_halted = n_halted; m_count = n_count;
    endtask

    // One clock: model sees the inputs as they stand before the edge; DUT
    // outputs are sampled 1 ns after the edge.
    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic s, input logic b, input logic [63:0] t);
        reset = r; Stall = s; Branch_Taken = b; Branch_Target = t;
    endtask

    task automatic expect_all(input string tag, input logic [63:0] addr, input logic [63:0] ipc,
                              input logic valid, input logic [31:0] cnt, input logic halt);
        check({tag, ".addr"},   Inst_Address, addr);
        check({tag, ".ifidpc"}, IFID_PC, ipc);
        check({tag, ".valid"},  64'(IFID_Valid), 64'(valid));
        check({tag, ".instr"},  64'(IFID_Instruction), 64'(valid ? mem_word(ipc) : NOP));
        check({tag, ".count"},  64'(Fetch_Count), 64'(cnt));
        check({tag, ".halted"}, 64'(Halted), 64'(halt));
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        rst;
        logic        stall;
        logic        br;
        logic [63:0] tgt;
        logic [63:0] e_addr;
        logic [63:0] e_ifid_pc;
        logic        e_valid;
        logic [31:0] e_count;
        logic        e_halted;
    } vec_t;

    vec_t vecs[9];

    initial begin
        //          rst   stall br    tgt       addr      ifid_pc  v     cnt    halt
        vecs[0] = '{1'b1, 1'b0, 1'b0, 64'h0,    64'h0,    64'h0,   1'b0, 32'd0, 1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 64'h0,    64'h4,    64'h0,   1'b1, 32'd1, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 64'h0,    64'h8,    64'h4,   1'b1, 32'd2, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 64'h0,    64'hC,    64'h8,   1'b1, 32'd3, 1'b0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 64'h0,    64'hC,    64'h8,   1'b1, 32'd3, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 64'h0,    64'hC,    64'h8,   1'b1, 32'd3, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 1'b1, 64'h2E,   64'h2C,   64'h8,   1'b0, 32'd3, 1'b0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 64'h0,    64'h30,   64'h2C,  1'b1, 32'd4, 1'b0};
        vecs[8] = '{1'b1, 1'b0, 1'b1, 64'h40,   64'h0,    64'h0,   1'b0, 32'd0, 1'b0};

        for (int i = 0; i < 9; i++) begin
            set_in(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].tgt);
            cycle();
            expect_all($sformatf("vec%0d", i), vecs[i].e_addr, vecs[i].e_ifid_pc,
                       vecs[i].e_valid, vecs[i].e_count, vecs[i].e_halted);
        end

        // ---- free run to the end of memory, halt, and resume ----
        set_in(1'b0, 1'b0, 1'b0, 64'h0);
        for (int i = 0; i < 20; i++) cycle();
        expect_all("run20", 64'd80, 64'd76, 1'b1, 32'd20, 1'b0);
        cycle();
        expect_all("halt", 64'd80, 64'd76, 1'b0, 32'd20, 1'b1);
        cycle();
        expect_all("halt2", 64'd80, 64'd76, 1'b0, 32'd20, 1'b1);
        set_in(1'b0, 1'b1, 1'b0, 64'h0);
        cycle();
        expect_all("halt_stall", 64'd80, 64'd76, 1'b0, 32'd20, 1'b1);
        set_in(1'b0, 1'b0, 1'b1, 64'h0);
        cycle();
        expect_all("br_resume", 64'd0, 64'd76, 1'b0, 32'd20, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 64'h0);
        cycle();
        expect_all("resume_fetch", 64'd4, 64'd0, 1'b1, 32'd21, 1'b0);

        // Last legal word: PC = 76 fetches, then halts.
        set_in(1'b0, 1'b0, 1'b1, 64'd76);
        cycle();
        set_in(1'b0, 1'b0, 1'b0, 64'h0);
        cycle();
        expect_all("edge76", 64'd80, 64'd76, 1'b1, 32'd22, 1'b0);

        // Out-of-range target enters RUN first, then halts on the next edge.
        set_in(1'b0, 1'b0, 1'b1, 64'h100);
        cycle();
        expect_all("br_oor", 64'h100, 64'd76, 1'b0, 32'd22, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 64'h0);
        cycle();
        expect_all("br_oor_halt", 64'h100, 64'd76, 1'b0, 32'd22, 1'b1);

        // PC near 2^64: PC+4 must not wrap into range.
        set_in(1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        cycle();
        expect_all("br_top", 64'hFFFF_FFFF_FFFF_FFFC, 64'd76, 1'b0, 32'd22, 1'b0);
        set_in(1'b0, 1'b0, 1'b0, 64'h0);
        cycle();
        expect_all("top_halt", 64'hFFFF_FFFF_FFFF_FFFC, 64'd76, 1'b0, 32'd22, 1'b1);

        // Reset while HALTED and stalled.
        set_in(1'b1, 1'b1, 1'b0, 64'h0);
        cycle();
        expect_all("rst_halted", 64'd0, 64'd0, 1'b0, 32'd0, 1'b0);

        // ---- randomized run against the reference model ----
        for (int i = 0; i < 600; i++) begin
            logic [63:0] tgt;
            if ($urandom_range(0, 7) == 0)
                tgt = {$urandom(), $urandom()};
            else
                tgt = 64'($urandom_range(0, 100));
            set_in($urandom_range(0, 49) == 0, $urandom_range(0, 4) == 0,
                   $urandom_range(0, 11) == 0, tgt);
            cycle();
            check($sformatf("rnd%0d.addr", i),   Inst_Address, m_pc);
            check($sformatf("rnd%0d.ifidpc", i), IFID_PC, m_ifid_pc);
            check($sformatf("rnd%0d.instr", i),  64'(IFID_Instruction), 64'(m_ifid_instr));
            check($sformatf("rnd%0d.valid", i),  64'(IFID_Valid), 64'(m_valid));
            check($sformatf("rnd%0d.halted", i), 64'(Halted), 64'(m_halted));
            check($sformatf("rnd%0d.count", i),  64'(Fetch_Count), 64'(m_count));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
